pdu_input_front: RTL and testbench
==================================

Name: pdu_input_front

Overview:
Input front end for the PDU top level. It sits between the board buttons/switches and the PDU control logic.
- Synchronises and debounces the five buttons and sixteen switches.
- Turns button presses into single-cycle command pulses.
- Turns switch events into hex digits, assembled in a 32-bit entry buffer that the PDU reads on the enter pulse.

Parameters:
DB_CYCLES, 1000000, consecutive stable cycles needed to accept a new input level (>=1; benches use 4).

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous reset, active-high
btn_step  input  1  raw step button
btn_cont  input  1  raw continue button
btn_chk  input  1  raw check button
btn_ent  input  1  raw enter button
btn_del  input  1  raw delete button
sw  input  16  raw hex-entry switches
step_p  output  1  one-cycle pulse per step press
cont_p  output  1  one-cycle pulse per continue press
chk_p  output  1  one-cycle pulse per check press
ent_p  output  1  one-cycle pulse per enter press; din valid in same cycle
del_p  output  1  one-cycle pulse per delete press
din  output  32  entry buffer, most recent digit in [3:0]
digit_cnt  output  4  digits held, 0..8

Behaviour:
- Reset (synchronous, active-high):
  - All synchroniser flops, debounce counters and stable levels clear to 0.
  - din=0, digit_cnt=0, all pulses 0.
  - Reset mid-debounce discards partial counts; no pulse follows the reset.
- Synchroniser: two-flop chain (s1, s2) on each of the 21 inputs.
- Debounce, per input:
  - Counter of width $clog2(DB_CYCLES+1).
  - On each edge where s2 != stable, the counter increments; on any edge where s2 == stable, it clears.
  - On the DB_CYCLES-th consecutive mismatching edge, stable takes s2 and the counter clears.
  - Glitches shorter than DB_CYCLES cycles are ignored.
- Edge detect:
  - Pulse = stable & ~stable_d.
  - High for exactly one cycle.
  - Latency: input first sampled at new level on edge 0 -> pulse high in the cycle after edge DB_CYCLES+1.
  - Holding a button produces one pulse only.
- Switch event: rising edge of stable sw[i] (see optional feature for falling edges).
  - Several switches rising in the same cycle: lowest index wins, the rest are dropped.
- Buffer update on the edge that ends a pulse cycle, priority ent > del > digit:
  - ent_p: din holds the entered value during the pulse cycle. Next edge: din=0, digit_cnt=0. A simultaneous del or digit is dropped.
  - del_p: din <= {4'h0, din[31:4]}; digit_cnt decrements. At digit_cnt=0, din and digit_cnt are unchanged, but del_p still pulses.
  - Digit i: din <= {din[27:0], i[3:0]}; digit_cnt = min(cnt+1, 8). At 8, the oldest digit is shifted out and the count saturates.
- step_p, cont_p and chk_p have no effect on the buffer.
- Pulses from different buttons may coincide; each is output independently.

Optional Feature:
Macro SW_BOTH_EDGE_EN.
- Defined: both rising and falling edges of stable sw[i] count as entry of digit i, so each flip of a physical switch enters one digit. Same priority and lowest-index rules apply.
- Undefined: rising edges only; a switch must go up then down to enter a digit.

Test Plan:
1. DB_CYCLES=4; reset; pulse sw[3], sw[0], sw[8], sw[0] in sequence, each high 10 cycles then low 10 -> din=32'h0000_3080, digit_cnt=4.
2. From (1): press btn_del 8 cycles -> one del_p, din=32'h0000_0308, digit_cnt=3. Then press btn_ent -> one ent_p with din=32'h0000_0308; next cycle din=0, digit_cnt=0.
3. btn_cont high 3 cycles -> no cont_p. btn_cont high 20 cycles -> exactly one cont_p, first high DB_CYCLES+1=5 edges after the first sampling edge.
4. Enter digits 1..9 in order -> din=32'h2345_6789, digit_cnt=8.
5. sw[5] and sw[2] rise in the same cycle -> only digit 2 appended. btn_ent and btn_del stable-rise in the same cycle -> ent_p and del_p both pulse, buffer cleared, no shift. btn_del at digit_cnt=0 -> del_p, din and digit_cnt unchanged.
6. Assert rst 2 cycles midway through a btn_step debounce -> all outputs 0, no step_p afterwards. With SW_BOTH_EDGE_EN defined, sw[7] up then down -> din=32'h0000_0077, digit_cnt=2.

Source files
------------

// File: rtl/pdu_input_front.sv
// pdu_input_front: board input front end for the PDU.
//   Synchronises and debounces five buttons and sixteen switches, turns button
//   presses into one-cycle command pulses, and turns switch events into hex
//   digits shifted into a 32-bit entry buffer.
//
// Optional build macro:
//   SW_BOTH_EDGE_EN - when defined, both rising and falling edges of a debounced
//                     switch enter its digit; otherwise only rising edges do.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   btn_step   raw step button
//   btn_cont   raw continue button
//   btn_chk    raw check button
//   btn_ent    raw enter button
//   btn_del    raw delete button
//   sw[15:0]   raw hex-entry switches
//   step_p     one-cycle pulse per step press
//   cont_p     one-cycle pulse per continue press
//   chk_p      one-cycle pulse per check press
//   ent_p      one-cycle pulse per enter press; din is the entered value meanwhile
//   del_p      one-cycle pulse per delete press
//   din        entry buffer, most recent digit in [3:0]
//   digit_cnt  number of digits held, 0..8
module pdu_input_front #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_cont,
    input  logic        btn_chk,
    input  logic        btn_ent,
    input  logic        btn_del,
    input  logic [15:0] sw,
    output logic        step_p,
    output logic        cont_p,
    output logic        chk_p,
    output logic        ent_p,
    output logic        del_p,
    output logic [31:0] din,
    output logic [3:0]  digit_cnt
);

    localparam int unsigned NBTN = 5;
    localparam int unsigned NSW  = 16;
    localparam int unsigned NIN  = NBTN + NSW;
    localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [3:0] MAX_DIGITS = 4'd8;

    // Bit map of the combined input vector: buttons in [4:0], switches in [20:5]
    localparam int unsigned B_ENT = 3;
    localparam int unsigned B_DEL = 4;

    logic [NIN-1:0]  raw;
    logic [NIN-1:0]  s1;
    logic [NIN-1:0]  s2;
    logic [NIN-1:0]  stable;
    logic [NIN-1:0]  stable_n;
    logic [CW-1:0]   db_cnt   [NIN];
    logic [CW-1:0]   db_cnt_n [NIN];

    logic [NBTN-1:0] pulse;
    logic [NBTN-1:0] pulse_n;
    logic [NSW-1:0]  sw_ev;
    logic            dig_vld;
    logic            dig_vld_n;
    logic [3:0]      dig_idx;
    logic [3:0]      dig_idx_n;

    logic [31:0]     din_n;
    logic [3:0]      digit_cnt_n;

    assign raw = {sw, btn_del, btn_ent, btn_chk, btn_cont, btn_step};

    // Debounce: accept s2 after DB_CYCLES consecutive mismatching edges
    always_comb begin
        stable_n = stable;
        for (int i = 0; i < int'(NIN); i++) begin
            db_cnt_n[i] = '0;
            if (s2[i] != stable[i]) begin
                if (db_cnt[i] == CNT_LAST) begin
                    stable_n[i] = s2[i];
                end else begin
                    db_cnt_n[i] = db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge detect on the next stable value so pulses leave a register directly
    always_comb begin
        pulse_n = stable_n[NBTN-1:0] & ~stable[NBTN-1:0];
`ifdef SW_BOTH_EDGE_EN
        sw_ev   = stable_n[NIN-1:NBTN] ^ stable[NIN-1:NBTN];
`else
        sw_ev   = stable_n[NIN-1:NBTN] & ~stable[NIN-1:NBTN];
`endif
    end

    // Lowest-index switch event wins; scanning downward leaves the lowest hit
    always_comb begin
        dig_vld_n = |sw_ev;
        dig_idx_n = '0;
        for (int i = int'(NSW) - 1; i >= 0; i--) begin
            if (sw_ev[i]) begin
                dig_idx_n = 4'(i);
            end
        end
    end

    // Entry buffer: updates on the edge closing a pulse cycle, ent > del > digit
    always_comb begin
        din_n       = din;
        digit_cnt_n = digit_cnt;
        if (pulse[B_ENT]) begin
            din_n       = '0;
            digit_cnt_n = '0;
        end else if (pulse[B_DEL]) begin
            if (digit_cnt != 4'd0) begin
                din_n       = {4'h0, din[31:4]};
                digit_cnt_n = digit_cnt - 4'd1;
            end
        end else if (dig_vld) begin
            din_n = {din[27:0], dig_idx};
            if (digit_cnt != MAX_DIGITS) begin
                digit_cnt_n = digit_cnt + 4'd1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            stable    <= '0;
            pulse     <= '0;
            dig_vld   <= 1'b0;
            dig_idx   <= '0;
            din       <= '0;
            digit_cnt <= '0;
            for (int i = 0; i < int'(NIN); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1        <= raw;
            s2        <= s1;
            stable    <= stable_n;
            pulse     <= pulse_n;
            dig_vld   <= dig_vld_n;
            dig_idx   <= dig_idx_n;
            din       <= din_n;
            digit_cnt <= digit_cnt_n;
            for (int i = 0; i < int'(NIN); i++) begin
                db_cnt[i] <= db_cnt_n[i];
            end
        end
    end

    assign step_p = pulse[0];
    assign cont_p = pulse[1];
    assign chk_p  = pulse[2];
    assign ent_p  = pulse[B_ENT];
    assign del_p  = pulse[B_DEL];

endmodule

// File: tb/tb_pdu_input_front.sv
// Testbench for pdu_input_front: directed scenarios followed by random button,
// switch and glitch activity, checked against a digit-queue model of the entry
// buffer and per-button press counts.
module tb_pdu_input_front;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic        step_p, cont_p, chk_p, ent_p, del_p;
    logic [31:0] din;
    logic [3:0]  digit_cnt;

    pdu_input_front #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn[0]),
        .btn_cont  (btn[1]),
        .btn_chk   (btn[2]),
        .btn_ent   (btn[3]),
        .btn_del   (btn[4]),
        .sw        (sw),
        .step_p    (step_p),
        .cont_p    (cont_p),
        .chk_p     (chk_p),
        .ent_p     (ent_p),
        .del_p     (del_p),
        .din       (din),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed pulse counts and the din value seen during the last ent_p
    int          seen [5];
    int          expc [5];
    logic [31:0] ent_din_seen = '0;
    logic [31:0] ent_din_exp  = '0;

    // Model: digits held, oldest first
    logic [3:0]  q[$];

    initial begin
        for (int b = 0; b < 5; b++) begin
            seen[b] = 0;
            expc[b] = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            seen[0] += int'(step_p);
            seen[1] += int'(cont_p);
            seen[2] += int'(chk_p);
            seen[3] += int'(ent_p);
            seen[4] += int'(del_p);
            if (ent_p) ent_din_seen = din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_din();
        logic [31:0] v = '0;
        foreach (q[k]) v = {v[27:0], q[k]};
        return v;
    endfunction

    task automatic model_digit(input int i);
        q.push_back(4'(i));
        if (q.size() > 8) void'(q.pop_front());
`ifdef SW_BOTH_EDGE_EN
        // the release is a second flip of the switch
        q.push_back(4'(i));
        if (q.size() > 8) void'(q.pop_front());
`endif
    endtask

    task automatic model_btn(input int b);
        expc[b]++;
        if (b == 3) begin
            ent_din_exp = model_din();
            q.delete();
        end else if (b == 4 && q.size() > 0) begin
            void'(q.pop_back());
        end
    endtask

    task automatic verify(input string tag);
        check({tag, "_din"}, din, model_din());
        check({tag, "_cnt"}, 32'(digit_cnt), 32'(q.size()));
        check({tag, "_step"}, 32'(seen[0]), 32'(expc[0]));
        check({tag, "_cont"}, 32'(seen[1]), 32'(expc[1]));
        check({tag, "_chk"},  32'(seen[2]), 32'(expc[2]));
        check({tag, "_ent"},  32'(seen[3]), 32'(expc[3]));
        check({tag, "_del"},  32'(seen[4]), 32'(expc[4]));
        check({tag, "_entval"}, ent_din_seen, ent_din_exp);
    endtask

    task automatic press_sw(input int i, input int hi, input int lo);
        sw[i] = 1'b1;
        tick(hi);
        sw[i] = 1'b0;
        tick(lo);
        model_digit(i);
    endtask

    task automatic press_btn(input int b, input int h);
        btn[b] = 1'b1;
        tick(h);
        btn[b] = 1'b0;
        tick(12);
        model_btn(b);
    endtask

    // Short pulse on one of the 21 inputs that must be filtered out
    task automatic glitch(input int idx, input int len);
        if (idx < 5) btn[idx] = 1'b1; else sw[idx-5] = 1'b1;
        tick(len);
        if (idx < 5) btn[idx] = 1'b0; else sw[idx-5] = 1'b0;
        tick(8);
    endtask

    initial begin
        int lat;
        bit found;
        int a, b2, op;

        rst = 1'b1;
        btn = '0;
        sw  = '0;
        tick(3);
        check("rst_din", din, 32'h0);
        check("rst_cnt", 32'(digit_cnt), 32'h0);
        check("rst_pulses", 32'({step_p, cont_p, chk_p, ent_p, del_p}), 32'h0);
        rst = 1'b0;
        tick(2);

        // Digits 3,0,8,0
        press_sw(3, 10, 10);
        press_sw(0, 10, 10);
        press_sw(8, 10, 10);
        press_sw(0, 10, 10);
        verify("seq3080");

        press_btn(4, 8);
        verify("del1");
        press_btn(3, 8);
        verify("ent1");

        // Too-short continue press is ignored
        glitch(1, 3);
        verify("cont_short");

        // Continue latency: first pulse DB+1 edges after the first sampling edge
        btn[1] = 1'b1;
        @(posedge clk);
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (cont_p) begin
                lat = k;
                found = 1'b1;
            end
        end
        check("cont_latency", 32'(lat), 32'(DB + 1));
        tick(12);
        btn[1] = 1'b0;
        tick(12);
        model_btn(1);
        verify("cont_long");

        // Digits 1..9 saturate at eight
        for (int i = 1; i <= 9; i++) press_sw(i, 10, 10);
        verify("sat9");

        // Two switches together: lowest index wins
        sw = 16'h0024;
        tick(10);
        sw = 16'h0000;
        tick(10);
        model_digit(2);
        verify("sw_pair");

        // Enter and delete together: clear wins, no shift
        btn[3] = 1'b1;
        btn[4] = 1'b1;
        tick(10);
        btn = '0;
        tick(12);
        model_btn(3);
        expc[4]++;
        verify("ent_del");

        press_btn(4, 8);
        verify("del_empty");

        // Reset in the middle of a step debounce
        press_sw(6, 10, 10);
        btn[0] = 1'b1;
        tick(3);
        rst = 1'b1;
        btn[0] = 1'b0;
        tick(2);
        check("mrst_din", din, 32'h0);
        check("mrst_cnt", 32'(digit_cnt), 32'h0);
        check("mrst_pulses", 32'({step_p, cont_p, chk_p, ent_p, del_p}), 32'h0);
        rst = 1'b0;
        q.delete();
        tick(20);
        verify("mrst_after");

        // Random activity
        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                press_sw(int'($urandom_range(0, 15)), int'($urandom_range(6, 14)), int'($urandom_range(8, 14)));
            end else if (op == 5) begin
                press_btn(4, int'($urandom_range(6, 30)));
            end else if (op == 6) begin
                press_btn(3, int'($urandom_range(6, 30)));
            end else if (op == 7) begin
                press_btn(int'($urandom_range(0, 2)), int'($urandom_range(6, 30)));
            end else if (op == 8) begin
                glitch(int'($urandom_range(0, 20)), int'($urandom_range(1, DB - 1)));
            end else begin
                a  = int'($urandom_range(0, 15));
                b2 = (a + int'($urandom_range(1, 15))) % 16;
                sw[a]  = 1'b1;
                sw[b2] = 1'b1;
                tick(10);
                sw = '0;
                tick(10);
                model_digit(a < b2 ? a : b2);
            end
            verify("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
